// File: rtl/db_pkg.sv
// Shared types and helpers for the host-side debug command initiator.
package db_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned RSP_BYTES = 5;
  localparam int unsigned RSP_W     = RSP_BYTES * BYTE_W;
  localparam int unsigned CNT_W     = 3;

  localparam logic [BYTE_W-1:0] STAT_OK    = 8'h00;
  localparam logic [BYTE_W-1:0] STAT_ERR   = 8'hFF;
  localparam logic [BYTE_W-1:0] STAT_BADOP = 8'hEE;

  typedef enum logic [BYTE_W-1:0] {
    OP_PAUSE    = 8'h01,
    OP_RESUME   = 8'h02,
    OP_RESET    = 8'h03,
    OP_READ_PC  = 8'h04,
    OP_REG_RD   = 8'h05,
    OP_REG_WR   = 8'h06,
    OP_MEM_RD_W = 8'h07,
    OP_MEM_WR_W = 8'h08,
    OP_MEM_RD_B = 8'h09,
    OP_MEM_WR_B = 8'h0A
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE, S_GET_ADDR, S_GET_DATA, S_ISSUE, S_WAIT, S_BAD, S_SEND
  } state_e;

  typedef struct packed {
    logic pause;
    logic resume;
    logic reset_mcu;
    logic reg_rd;
    logic reg_wr;
    logic mem_rd;
    logic mem_wr;
  } cmd_t;

  function automatic logic op_known(input logic [BYTE_W-1:0] op);
    return (op >= 8'h01) && (op <= 8'h0A);
  endfunction

  // Argument bytes following the opcode: 0, 4 (addr) or 8 (addr + data).
  function automatic logic [3:0] arg_bytes(input logic [BYTE_W-1:0] op);
    case (op)
      OP_REG_RD, OP_MEM_RD_W, OP_MEM_RD_B: return 4'd4;
      OP_REG_WR, OP_MEM_WR_W, OP_MEM_WR_B: return 4'd8;
      default:                             return 4'd0;
    endcase
  endfunction

  function automatic logic is_read(input logic [BYTE_W-1:0] op);
    return (op == OP_REG_RD) || (op == OP_MEM_RD_W) ||
           (op == OP_MEM_RD_B) || (op == OP_READ_PC);
  endfunction

  function automatic logic is_byte(input logic [BYTE_W-1:0] op);
    return (op == OP_MEM_RD_B) || (op == OP_MEM_WR_B);
  endfunction

  function automatic cmd_t op_cmd(input logic [BYTE_W-1:0] op);
    cmd_t c;
    c = '0;
    case (op)
      OP_PAUSE:                 c.pause     = 1'b1;
      OP_RESUME:                c.resume    = 1'b1;
      OP_RESET:                 c.reset_mcu = 1'b1;
      OP_REG_RD:                c.reg_rd    = 1'b1;
      OP_REG_WR:                c.reg_wr    = 1'b1;
      OP_MEM_RD_W, OP_MEM_RD_B: c.mem_rd    = 1'b1;
      OP_MEM_WR_W, OP_MEM_WR_B: c.mem_wr    = 1'b1;
      default:                  c           = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/db_tx_serializer.sv
// Streams up to five left-aligned response bytes to the UART transmitter.
module db_tx_serializer
  import db_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [RSP_W-1:0]   bytes,
  input  logic [CNT_W-1:0]   count,
  input  logic               tx_ready,
  output logic [BYTE_W-1:0]  tx_data,
  output logic               tx_valid,
  output logic               done
);

  logic [RSP_W-1:0] shreg_q;
  logic [CNT_W-1:0] left_q;

  // The head byte is always the one on the wire; shifting in zeros leaves tx_data 0 when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q  <= '0;
      left_q   <= '0;
      tx_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        shreg_q  <= bytes;
        left_q   <= count;
        tx_valid <= (count != '0);
      end else if (tx_valid && tx_ready) begin
        shreg_q <= {shreg_q[RSP_W-BYTE_W-1:0], BYTE_W'(0)};
        left_q  <= left_q - CNT_W'(1);
        if (left_q == CNT_W'(1)) begin
          tx_valid <= 1'b0;
          done     <= 1'b1;
        end
      end
    end
  end

  assign tx_data = shreg_q[RSP_W-1 -: BYTE_W];

endmodule

// File: rtl/db_cmd_initiator.sv
// Host-side debug initiator: UART command frames in, one MCU transaction, response bytes out.
module db_cmd_initiator
  import db_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter int unsigned BUSY_LIMIT     = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [31:0]       pc,
  input  logic              mcu_busy,
  input  logic              error,
  input  logic [31:0]       d_rd,
  output logic              valid,
  output logic              pause,
  output logic              resume,
  output logic              reset_mcu,
  output logic              reg_rd,
  output logic              reg_wr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              mem_rw_byte,
  output logic [31:0]       addr,
  output logic [31:0]       d_in
);

  localparam int unsigned CTR_W = 32;

  state_e              state_q, state_d;
  logic [BYTE_W-1:0]   opcode_q, opcode_d;
  logic [WORD_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   d_in_q, d_in_d;
  logic [WORD_W-1:0]   pc_q, pc_d;
  logic [CTR_W-1:0]    tmo_q, tmo_d;
  logic [CTR_W-1:0]    busy_q, busy_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  cmd_t                cmd_q, cmd_d;
  logic                valid_q, valid_d;
  logic                mrb_q, mrb_d;

  logic                load_c;
  logic [RSP_W-1:0]    rsp_c;
  logic [CNT_W-1:0]    rsp_cnt_c;
  logic [BYTE_W-1:0]   op_c;
  logic [BYTE_W-1:0]   stat_c;
  logic [WORD_W-1:0]   rd_word_c;
  logic                ser_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      opcode_q   <= '0;
      addr_q     <= '0;
      d_in_q     <= '0;
      pc_q       <= '0;
      tmo_q      <= '0;
      busy_q     <= '0;
      byte_cnt_q <= '0;
      cmd_q      <= '0;
      valid_q    <= 1'b0;
      mrb_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      addr_q     <= addr_d;
      d_in_q     <= d_in_d;
      pc_q       <= pc_d;
      tmo_q      <= tmo_d;
      busy_q     <= busy_d;
      byte_cnt_q <= byte_cnt_d;
      cmd_q      <= cmd_d;
      valid_q    <= valid_d;
      mrb_q      <= mrb_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    addr_d     = addr_q;
    d_in_d     = d_in_q;
    pc_d       = pc_q;
    tmo_d      = tmo_q;
    busy_d     = busy_q;
    byte_cnt_d = byte_cnt_q;
    cmd_d      = '0;
    valid_d    = 1'b0;
    mrb_d      = 1'b0;
    load_c     = 1'b0;
    rsp_c      = '0;
    rsp_cnt_c  = '0;
    op_c       = (state_q == S_IDLE) ? rx_data : opcode_q;
    stat_c     = (!mcu_busy && !error) ? STAT_OK : STAT_ERR;
    rd_word_c  = is_byte(opcode_q) ? {24'h0, d_rd[7:0]} : d_rd;

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          opcode_d   = rx_data;
          byte_cnt_d = '0;
          tmo_d      = '0;
          pc_d       = pc;
          if (!op_known(rx_data))               state_d = S_BAD;
          else if (arg_bytes(rx_data) != 4'd0)  state_d = S_GET_ADDR;
          else                                  state_d = S_ISSUE;
        end
      end
      S_GET_ADDR: begin
        if (rx_valid) begin
          addr_d     = {addr_q[23:0], rx_data};
          tmo_d      = '0;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3)
            state_d = (arg_bytes(opcode_q) == 4'd8) ? S_GET_DATA : S_ISSUE;
        end else if (tmo_q == CTR_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + CTR_W'(1);
        end
      end
      S_GET_DATA: begin
        if (rx_valid) begin
          d_in_d     = {d_in_q[23:0], rx_data};
          tmo_d      = '0;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) state_d = S_ISSUE;
        end else if (tmo_q == CTR_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + CTR_W'(1);
        end
      end
      S_ISSUE: begin
        busy_d = '0;
        // Read-PC never touches the MCU; answer straight from the sampled pc.
        if (opcode_q == OP_READ_PC) begin
          load_c    = 1'b1;
          rsp_c     = {pc_q, STAT_OK};
          rsp_cnt_c = CNT_W'(5);
          state_d   = S_SEND;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!mcu_busy || busy_q == CTR_W'(BUSY_LIMIT - 1)) begin
          load_c  = 1'b1;
          state_d = S_SEND;
          if (is_read(opcode_q)) begin
            rsp_c     = {rd_word_c, stat_c};
            rsp_cnt_c = CNT_W'(5);
          end else begin
            rsp_c     = {stat_c, 32'h0};
            rsp_cnt_c = CNT_W'(1);
          end
        end else begin
          busy_d = busy_q + CTR_W'(1);
        end
      end
      S_BAD: begin
        load_c    = 1'b1;
        rsp_c     = {STAT_BADOP, 32'h0};
        rsp_cnt_c = CNT_W'(1);
        state_d   = S_SEND;
      end
      S_SEND: begin
        if (ser_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Strobes are registered so they line up with the single ISSUE cycle.
    if (state_d == S_ISSUE) begin
      cmd_d   = op_cmd(op_c);
      valid_d = |cmd_d;
      mrb_d   = is_byte(op_c);
    end
  end

  db_tx_serializer u_ser (
    .clk      (clk),
    .reset    (reset),
    .load     (load_c),
    .bytes    (rsp_c),
    .count    (rsp_cnt_c),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .done     (ser_done)
  );

  assign valid       = valid_q;
  assign pause       = cmd_q.pause;
  assign resume      = cmd_q.resume;
  assign reset_mcu   = cmd_q.reset_mcu;
  assign reg_rd      = cmd_q.reg_rd;
  assign reg_wr      = cmd_q.reg_wr;
  assign mem_rd      = cmd_q.mem_rd;
  assign mem_wr      = cmd_q.mem_wr;
  assign mem_rw_byte = mrb_q;
  assign addr        = addr_q;
  assign d_in        = d_in_q;

endmodule

// File: tb/tb_db_cmd_initiator.sv
// Directed bench for db_cmd_initiator: frame table plus timeout, busy-limit, reset and stall sequences.
module tb_db_cmd_initiator;

  logic        clk, reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [31:0] pc, d_rd, addr, d_in;
  logic        mcu_busy, error;
  logic        valid, pause, resume, reset_mcu, reg_rd, reg_wr, mem_rd, mem_wr, mem_rw_byte;

  db_cmd_initiator #(.TIMEOUT_CYCLES(100), .BUSY_LIMIT(50)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .pc(pc),
    .mcu_busy(mcu_busy), .error(error), .d_rd(d_rd), .valid(valid),
    .pause(pause), .resume(resume), .reset_mcu(reset_mcu), .reg_rd(reg_rd),
    .reg_wr(reg_wr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rw_byte(mem_rw_byte),
    .addr(addr), .d_in(d_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  op;
    int          nargs;
    logic [31:0] a;
    logic [31:0] d;
    int          busy;
    logic [31:0] rd;
    logic        err;
    int          nvalid;
    logic [6:0]  strb;   // {pause,resume,reset_mcu,reg_rd,reg_wr,mem_rd,mem_wr}
    logic        mrb;
    int          ntx;
    logic [39:0] tx;     // expected response, first byte in [39:32]
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0, vcyc = 0, tcyc = 0;
  logic [7:0]  txq[$];
  logic [6:0]  vq[$];
  logic [31:0] aq[$], dq[$];
  logic        bq[$];
  int          mdl_busy = 0;
  logic [31:0] mdl_rd = '0;
  logic        mdl_err = 1'b0;
  vec_t        vecs[12];

  function automatic vec_t mkv(input logic [7:0] op, input int nargs, input logic [31:0] a,
                               input logic [31:0] d, input int busy, input logic [31:0] rd,
                               input logic err, input int nvalid, input logic [6:0] strb,
                               input logic mrb, input int ntx, input logic [39:0] tx);
    vec_t v;
    v.op = op; v.nargs = nargs; v.a = a; v.d = d; v.busy = busy; v.rd = rd; v.err = err;
    v.nvalid = nvalid; v.strb = strb; v.mrb = mrb; v.ntx = ntx; v.tx = tx;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Observer: accepted tx bytes and command strobes, sampled on the falling edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (tx_valid && tx_ready) begin
      if (txq.size() == 0) tcyc = cyc;
      txq.push_back(tx_data);
    end
    if (valid) begin
      vcyc = cyc;
      vq.push_back({pause, resume, reset_mcu, reg_rd, reg_wr, mem_rd, mem_wr});
      aq.push_back(addr);
      dq.push_back(d_in);
      bq.push_back(mem_rw_byte);
    end
  end

  // MCU model: on each command, hold busy for mdl_busy cycles with the read data ready.
  initial begin
    mcu_busy = 1'b0; d_rd = '0; error = 1'b0;
    forever begin
      @(negedge clk);
      if (valid) begin
        d_rd  = mdl_rd;
        error = mdl_err;
        if (mdl_busy > 0) begin
          mcu_busy = 1'b1;
          repeat (mdl_busy) @(posedge clk);
          #1 mcu_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick_n(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic clear_q();
    txq.delete(); vq.delete(); aq.delete(); dq.delete(); bq.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input vec_t v);
    logic [63:0] args;
    args = {v.a, v.d};
    send_byte(v.op);
    for (int i = 0; i < v.nargs; i++) send_byte(args[63-8*i -: 8]);
    pc = 32'h0BAD0BAD;
  endtask

  task automatic wait_tx(input int n);
    for (int k = 0; k < 3000 && txq.size() < n; k++) begin @(negedge clk); #1; end
  endtask

  task automatic wait_valid();
    for (int k = 0; k < 300 && vq.size() == 0; k++) begin @(negedge clk); #1; end
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    logic [7:0] eb;
    clear_q();
    mdl_busy = v.busy; mdl_rd = v.rd; mdl_err = v.err;
    pc = 32'hCAFE0123;
    send_frame(v);
    wait_tx(v.ntx);
    tick_n(10);
    chk({tag, "_nvalid"}, 64'(vq.size()), 64'(v.nvalid));
    if (v.nvalid > 0 && vq.size() > 0) begin
      chk({tag, "_strobe"}, 64'(vq[0]), 64'(v.strb));
      chk({tag, "_mrb"}, 64'(bq[0]), 64'(v.mrb));
      if (v.nargs >= 4) chk({tag, "_addr"}, 64'(aq[0]), 64'(v.a));
      if (v.nargs == 8) chk({tag, "_d_in"}, 64'(dq[0]), 64'(v.d));
    end
    chk({tag, "_ntx"}, 64'(txq.size()), 64'(v.ntx));
    for (int i = 0; i < v.ntx; i++) begin
      eb = v.tx[39-8*i -: 8];
      if (i < txq.size()) chk($sformatf("%s_tx%0d", tag, i), 64'(txq[i]), 64'(eb));
    end
  endtask

  initial begin
    vec_t v;
    logic [7:0] first;
    logic stable;
    reset = 1'b1; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b1; pc = 32'hCAFE0123;

    vecs[0]  = mkv(8'h05, 4, 32'h3,   32'h0,        10, 32'hDEADBEEF, 1'b0, 1, 7'b0001000, 1'b0, 5, 40'hDEADBEEF00);
    vecs[1]  = mkv(8'h08, 8, 32'h100, 32'h12345678,  3, 32'h0,        1'b0, 1, 7'b0000001, 1'b0, 1, 40'h0);
    vecs[2]  = mkv(8'h09, 4, 32'h4,   32'h0,         5, 32'h123456AB, 1'b1, 1, 7'b0000010, 1'b1, 5, 40'h000000ABFF);
    vecs[3]  = mkv(8'h55, 0, 32'h0,   32'h0,         0, 32'h0,        1'b0, 0, 7'b0000000, 1'b0, 1, 40'hEE00000000);
    vecs[4]  = mkv(8'h01, 0, 32'h0,   32'h0,         2, 32'h0,        1'b0, 1, 7'b1000000, 1'b0, 1, 40'h0);
    vecs[5]  = mkv(8'h02, 0, 32'h0,   32'h0,         0, 32'h0,        1'b0, 1, 7'b0100000, 1'b0, 1, 40'h0);
    vecs[6]  = mkv(8'h03, 0, 32'h0,   32'h0,         1, 32'h0,        1'b0, 1, 7'b0010000, 1'b0, 1, 40'h0);
    vecs[7]  = mkv(8'h04, 0, 32'h0,   32'h0,         0, 32'h0,        1'b0, 0, 7'b0000000, 1'b0, 5, 40'hCAFE012300);
    vecs[8]  = mkv(8'h06, 8, 32'h11,  32'hA5A50001,  4, 32'h0,        1'b0, 1, 7'b0000100, 1'b0, 1, 40'h0);
    vecs[9]  = mkv(8'h07, 4, 32'h20,  32'h0,         1, 32'h87654321, 1'b0, 1, 7'b0000010, 1'b0, 5, 40'h8765432100);
    vecs[10] = mkv(8'h0A, 8, 32'h30,  32'hAABBCCDD,  2, 32'h0,        1'b0, 1, 7'b0000001, 1'b1, 1, 40'h0);
    vecs[11] = mkv(8'h06, 8, 32'h12,  32'h1,         3, 32'h0,        1'b1, 1, 7'b0000100, 1'b0, 1, 40'hFF00000000);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", 64'({valid, pause, resume, reset_mcu, reg_rd, reg_wr, mem_rd, mem_wr,
                           mem_rw_byte, tx_valid}), 64'(0));
    chk("reset_addr", 64'(addr), 64'(0));
    chk("reset_d_in", 64'(d_in), 64'(0));
    chk("reset_tx_data", 64'(tx_data), 64'(0));
    @(posedge clk); #1 reset = 1'b0;

    for (int i = 0; i < 12; i++) run_frame(vecs[i], $sformatf("v%0d", i));

    // Partial frame followed by silence must be discarded without a response.
    clear_q();
    mdl_busy = 0;
    send_byte(8'h07); send_byte(8'h12); send_byte(8'h34);
    tick_n(150);
    chk("timeout_nvalid", 64'(vq.size()), 64'(0));
    chk("timeout_ntx", 64'(txq.size()), 64'(0));
    run_frame(vecs[4], "after_timeout");

    // MCU stuck busy: error status once the busy limit expires.
    v = mkv(8'h01, 0, 32'h0, 32'h0, 60, 32'h0, 1'b0, 1, 7'b1000000, 1'b0, 1, 40'hFF00000000);
    run_frame(v, "busy_limit");
    chk("busy_limit_latency", 64'((tcyc - vcyc) >= 50 && (tcyc - vcyc) <= 56), 64'(1));

    // Bytes arriving while a transaction is outstanding are dropped.
    clear_q();
    mdl_busy = 20; mdl_rd = 32'h55AA55AA; mdl_err = 1'b0; pc = 32'hCAFE0123;
    v = mkv(8'h05, 4, 32'h9, 32'h0, 20, 32'h55AA55AA, 1'b0, 1, 7'b0001000, 1'b0, 5, 40'h55AA55AA00);
    send_frame(v);
    wait_valid();
    tick_n(3);
    send_byte(8'h02);
    wait_tx(5);
    tick_n(30);
    chk("drop_nvalid", 64'(vq.size()), 64'(1));
    chk("drop_ntx", 64'(txq.size()), 64'(5));
    if (txq.size() == 5) chk("drop_tx0", 64'(txq[0]), 64'(8'h55));

    // Reset during WAIT: everything clears and no response follows.
    clear_q();
    mdl_busy = 40; mdl_rd = 32'h0; mdl_err = 1'b0;
    v = mkv(8'h05, 4, 32'h7, 32'h0, 40, 32'h0, 1'b0, 1, 7'b0001000, 1'b0, 5, 40'h0);
    send_frame(v);
    wait_valid();
    chk("rst_wait_valid_seen", 64'(vq.size()), 64'(1));
    tick_n(5);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_wait_ctrl", 64'({valid, pause, resume, reset_mcu, reg_rd, reg_wr, mem_rd, mem_wr,
                              mem_rw_byte, tx_valid}), 64'(0));
    chk("rst_wait_addr", 64'(addr), 64'(0));
    chk("rst_wait_tx_data", 64'(tx_data), 64'(0));
    @(posedge clk); #1 reset = 1'b0;
    clear_q();
    tick_n(60);
    chk("rst_wait_ntx", 64'(txq.size()), 64'(0));
    chk("rst_wait_nvalid", 64'(vq.size()), 64'(0));

    // Transmitter back-pressure: the presented byte must not move.
    clear_q();
    tx_ready = 1'b0;
    mdl_busy = 2; mdl_rd = 32'h01020304; mdl_err = 1'b0;
    v = mkv(8'h07, 4, 32'h40, 32'h0, 2, 32'h01020304, 1'b0, 1, 7'b0000010, 1'b0, 5, 40'h0102030400);
    send_frame(v);
    for (int k = 0; k < 300 && !tx_valid; k++) begin @(negedge clk); #1; end
    chk("stall_tx_valid", 64'(tx_valid), 64'(1));
    first = tx_data;
    stable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (tx_valid !== 1'b1 || tx_data !== first) stable = 1'b0;
    end
    chk("stall_stable", 64'(stable), 64'(1));
    chk("stall_first", 64'(first), 64'(8'h01));
    @(posedge clk); #1 tx_ready = 1'b1;
    wait_tx(5);
    tick_n(5);
    chk("stall_ntx", 64'(txq.size()), 64'(5));
    for (int i = 0; i < 5; i++) begin
      logic [7:0] eb;
      eb = v.tx[39-8*i -: 8];
      if (i < txq.size()) chk($sformatf("stall_tx%0d", i), 64'(txq[i]), 64'(eb));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
